can_bit_destuff: RTL
====================

CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

Interface
REQ-001 Parameter STUFF_LIMIT, default 5: number of consecutive equal bits after which a complementary stuff bit is expected.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sample_point  input  1  one-cycle strobe marking a valid rx_bit.
REQ-005 rx_bit  input  1  received bus bit (0 = dominant).
REQ-006 frame_start  input  1  one-cycle pulse; the rx_bit sampled in the same cycle (if any) is the SOF bit.
REQ-007 frame_abort  input  1  one-cycle pulse; returns the block to IDLE.
REQ-008 stuff_en  input  1  high while the bit stream is in the stuffed region (SOF through CRC sequence).
REQ-009 data_bit  output  1  de-stuffed bit.
REQ-010 data_valid  output  1  one-cycle pulse qualifying data_bit.
REQ-011 stuff_drop  output  1  one-cycle pulse: a stuff bit was removed.
REQ-012 stuff_error  output  1  one-cycle pulse: stuff rule violated.
REQ-013 err_flag  output  1  sticky error status, cleared by frame_start or rst.

Function
REQ-014 FSM states SHALL be IDLE, RUN, EXPECT_STUFF, ERROR.
REQ-015 All outputs SHALL be registered; each response appears exactly one clk after the sample_point cycle.
REQ-016 IDLE: sample_point ignored; no pulses; frame_start -> RUN, run count = 0.
REQ-017 RUN, stuff_en=1, sample_point: emit rx_bit with data_valid; if count=0 or rx_bit differs from last bit, count=1; otherwise count+1; last bit = rx_bit.
REQ-018 When count reaches STUFF_LIMIT in RUN, state SHALL move to EXPECT_STUFF in the same update.
REQ-019 EXPECT_STUFF, sample_point, rx_bit differs from last: no data_valid, stuff_drop=1, last=rx_bit, count=1, -> RUN.
REQ-020 EXPECT_STUFF, sample_point, rx_bit equals last: no data_valid, stuff_error=1, err_flag set, -> ERROR.
REQ-021 The removed stuff bit SHALL count as the first bit of the next run.
REQ-022 RUN or EXPECT_STUFF with stuff_en=0 at sample_point: bit passed through with data_valid, no check, count=0, state RUN.
REQ-023 ERROR: no data_valid/stuff_drop; leaves only via frame_start (-> RUN, err_flag cleared), frame_abort or rst (-> IDLE).
REQ-024 frame_start in any state SHALL reset count to 0 and enter RUN; a coincident sample_point is processed as the first bit with count=0.
REQ-025 frame_abort SHALL win over a simultaneous frame_start and suppress any coincident output pulse.
REQ-026 Count register SHALL be $clog2(STUFF_LIMIT+1) bits and never exceed STUFF_LIMIT.

Reset
REQ-027 rst SHALL force IDLE, count=0, last bit=1 (recessive), data_bit=1, data_valid=0, stuff_drop=0, stuff_error=0, err_flag=0, regardless of other inputs, mid-frame included.

Configuration
REQ-028 Macro CAN_DESTUFF_STATS_EN defined: adds outputs drop_count[7:0] and error_count[7:0], saturating at 255, incremented with stuff_drop/stuff_error, cleared only by rst.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 FSM state enum and default STUFF_LIMIT constant SHALL live in the shared CAN package (can_pkg), shared with the stuffing transmitter.
REQ-031 Run-length tracking (last bit + count + limit compare) SHALL be a sub-module can_run_counter; the FSM and output registers stay in can_bit_destuff.

Verification
REQ-032 frame_start + bits 0,0,0,0,0,1(stuff),0 with stuff_en=1 -> data_valid on 0,0,0,0,0,0; stuff_drop once after 6th bit.
REQ-033 bits 1,1,1,1,1,1 after frame_start -> 5 data_valid, then stuff_error pulse, err_flag=1, later bits give no data_valid until next frame_start.
REQ-034 bits 0x5 pattern 0,0,0,0,0,1,1,1,1,1,0 -> two stuff_drops (6th, 11th bit); stuff bit counted as run start.
REQ-035 stuff_en=0 with 8 ones -> 8 data_valid, no stuff_drop/stuff_error.
REQ-036 rst asserted after 3 equal bits, then frame_start + 2 equal bits -> no EXPECT_STUFF; all outputs at reset values during rst.
REQ-037 frame_abort and frame_start same cycle with sample_point -> state IDLE, no pulses; with CAN_DESTUFF_STATS_EN, 300 stuff drops -> drop_count=255.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN package: bit-destuffer FSM states and the default stuffing run length.
// The stuffing transmitter uses the same run-length constant.
package can_pkg;

   // Standard CAN stuffing: a complement bit follows five equal bits.
   localparam int unsigned StuffLimitDefault = 5;

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StRun         = 2'd1,
      StExpectStuff = 2'd2,
      StError       = 2'd3
   } destuff_state_e;

endpackage

// File: rtl/can_run_counter.sv
// Run-length tracker: remembers the last bit and the length of the current run of
// equal bits. It also flags when accepting bit_i would make the run reach StuffLimit.
module can_run_counter #(
   parameter int unsigned StuffLimit = can_pkg::StuffLimitDefault
) (
   input  logic clk_i,
   input  logic rst_i,       // synchronous, active-high
   input  logic clear_i,     // back to idle: count 0, last recessive
   input  logic restart_i,   // new frame: treat the current count as 0
   input  logic advance_i,   // accept bit_i into the run
   input  logic zero_i,      // unchecked bit: forget the run
   input  logic bit_i,
   output logic same_o,      // bit_i equals the last bit
   output logic limit_hit_o  // accepting bit_i makes the run StuffLimit long
);

   localparam int unsigned CntW = $clog2(StuffLimit + 1);
   localparam logic [CntW-1:0] Limit = CntW'(StuffLimit);

   logic [CntW-1:0] count_q, count_d, count_eff, run_next;
   logic            last_q, last_d;

   // Length the run would have if bit_i were accepted; saturates at the limit.
   always_comb begin
      count_eff = restart_i ? '0 : count_q;
      if (count_eff == '0 || bit_i != last_q) begin
         run_next = CntW'(1);
      end else if (count_eff >= Limit) begin
         run_next = Limit;
      end else begin
         run_next = count_eff + CntW'(1);
      end
      same_o      = (bit_i == last_q);
      limit_hit_o = (run_next == Limit);
   end

   // Next run state.
   always_comb begin
      count_d = count_q;
      last_d  = last_q;
      if (clear_i) begin
         count_d = '0;
         last_d  = 1'b1;
      end else if (advance_i) begin
         count_d = run_next;
         last_d  = bit_i;
      end else if (zero_i) begin
         count_d = '0;
         last_d  = bit_i;
      end else if (restart_i) begin
         count_d = '0;
      end
   end

   // Run registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         last_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive bit de-stuffer: removes stuff bits, flags stuff-rule violations.
// Optional build macro CAN_DESTUFF_STATS_EN adds saturating drop/error counters.
module can_bit_destuff
   import can_pkg::*;
#(
   parameter int unsigned STUFF_LIMIT = StuffLimitDefault
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_point,
   input  logic       rx_bit,
   input  logic       frame_start,
   input  logic       frame_abort,
   input  logic       stuff_en,
   output logic       data_bit,
   output logic       data_valid,
   output logic       stuff_drop,
   output logic       stuff_error,
   output logic       err_flag
`ifdef CAN_DESTUFF_STATS_EN
   ,
   output logic [7:0] drop_count,
   output logic [7:0] error_count
`endif
);

   destuff_state_e state_q, state_d, proc_state;
   logic data_bit_q, data_bit_d, valid_q, valid_d, drop_q, drop_d;
   logic serr_q, serr_d, err_flag_q, err_flag_d;
   logic cnt_clear, cnt_restart, cnt_adv, cnt_zero, cnt_same, cnt_limit_hit;

   can_run_counter #(
      .StuffLimit (STUFF_LIMIT)
   ) u_run_counter (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (cnt_clear),
      .restart_i   (cnt_restart),
      .advance_i   (cnt_adv),
      .zero_i      (cnt_zero),
      .bit_i       (rx_bit),
      .same_o      (cnt_same),
      .limit_hit_o (cnt_limit_hit)
   );

   // Next state and output pulses; abort beats start, start re-enters RUN before the bit.
   always_comb begin
      state_d     = state_q;
      data_bit_d  = data_bit_q;
      valid_d     = 1'b0;
      drop_d      = 1'b0;
      serr_d      = 1'b0;
      err_flag_d  = err_flag_q;
      cnt_clear   = 1'b0;
      cnt_restart = 1'b0;
      cnt_adv     = 1'b0;
      cnt_zero    = 1'b0;
      proc_state  = state_q;
      if (frame_abort) begin
         state_d   = StIdle;
         cnt_clear = 1'b1;
      end else begin
         if (frame_start) begin
            state_d     = StRun;
            proc_state  = StRun;
            err_flag_d  = 1'b0;
            cnt_restart = 1'b1;
         end
         if (sample_point) begin
            unique case (proc_state)
               StRun, StExpectStuff: begin
                  if (!stuff_en) begin
                     valid_d    = 1'b1;
                     data_bit_d = rx_bit;
                     cnt_zero   = 1'b1;
                     state_d    = StRun;
                  end else if (proc_state == StRun) begin
                     valid_d    = 1'b1;
                     data_bit_d = rx_bit;
                     cnt_adv    = 1'b1;
                     state_d    = cnt_limit_hit ? StExpectStuff : StRun;
                  end else if (!cnt_same) begin
                     drop_d  = 1'b1;
                     cnt_adv = 1'b1;
                     state_d = StRun;
                  end else begin
                     serr_d     = 1'b1;
                     err_flag_d = 1'b1;
                     state_d    = StError;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         data_bit_q <= 1'b1;
         valid_q    <= 1'b0;
         drop_q     <= 1'b0;
         serr_q     <= 1'b0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_bit_q <= data_bit_d;
         valid_q    <= valid_d;
         drop_q     <= drop_d;
         serr_q     <= serr_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign data_bit    = data_bit_q;
   assign data_valid  = valid_q;
   assign stuff_drop  = drop_q;
   assign stuff_error = serr_q;
   assign err_flag    = err_flag_q;

`ifdef CAN_DESTUFF_STATS_EN
   logic [7:0] drop_count_q, drop_count_d, error_count_q, error_count_d;

   // Saturating event counters, cleared only by reset.
   always_comb begin
      drop_count_d  = drop_count_q;
      error_count_d = error_count_q;
      if (drop_d && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      if (serr_d && error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count_q  <= '0;
         error_count_q <= '0;
      end else begin
         drop_count_q  <= drop_count_d;
         error_count_q <= error_count_d;
      end
   end

   assign drop_count  = drop_count_q;
   assign error_count = error_count_q;
`endif

endmodule
